isqrt_pipe: RTL
===============

ISQRT_PIPE -- requirements
Module: isqrt_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: radicand width; even, 4..64.
REQ-002 SHALL have parameter TAG_W, default 8: width of the sideband tag carried alongside each operand.
REQ-003 SHALL define derived constant N_STAGES = WIDTH/2 (16 at default); not overridable.
REQ-004 SHALL have port clock  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1: x and in_tag are valid this cycle.
REQ-007 SHALL have port in_ready  output  1: pipeline accepts an operand this cycle.
REQ-008 SHALL have port x  input  WIDTH: unsigned radicand.
REQ-009 SHALL have port in_tag  input  TAG_W: opaque tag, returned unmodified with the result.
REQ-010 SHALL have port out_valid  output  1: y, rem and out_tag hold a result.
REQ-011 SHALL have port out_ready  input  1: consumer accepts the result this cycle.
REQ-012 SHALL have port y  output  WIDTH/2: floor(sqrt(x)).
REQ-013 SHALL have port rem  output  WIDTH/2+1: x - y*y.
REQ-014 SHALL have port out_tag  output  TAG_W: tag of the operand that produced y.

Function
REQ-015 SHALL implement a digit-by-digit (restoring) square root, resolving exactly one root bit per stage, MSB first, over N_STAGES registered stages.
REQ-016 SHALL use, per stage, remainder width WIDTH/2+2 bits internally, so the trial subtraction never overflows for any x, including all-ones.
REQ-017 SHALL compute a global advance enable: en = !out_valid || out_ready.
REQ-018 SHALL drive in_ready = en, combinationally; an operand transfers when in_valid && in_ready.
REQ-019 SHALL, when en=1, shift every stage (data, tag, valid bit) forward by one; stage 0 loads the new operand, with valid = in_valid.
REQ-020 SHALL, when en=0, hold every stage register, including y, rem and out_tag, unchanged.
REQ-021 SHALL give latency exactly N_STAGES cycles from an accepted input to out_valid, with no backpressure.
REQ-022 SHALL sustain throughput of one result per cycle while out_ready=1.
REQ-023 SHALL propagate bubbles (in_valid=0) as invalid slots; bubbles are not collapsed, and out_valid=0 for them.
REQ-024 SHALL deliver results in acceptance order, with out_tag matching the operand.
REQ-025 SHALL guarantee y*y <= x < (y+1)*(y+1) and rem <= 2*y for every x, including x=0 and x=2^WIDTH-1.
REQ-026 SHALL keep y, rem and out_tag stable while out_valid=1 && out_ready=0.
REQ-027 SHALL not gate datapath registers on the valid bit; their contents when invalid are don't-care.

Reset
REQ-028 SHALL, on reset assertion, clear all stage valid bits asynchronously, giving out_valid=0 immediately.
REQ-029 SHALL reset y, rem and out_tag to 0.
REQ-030 SHALL discard operands in flight at reset; none emerge after deassertion.
REQ-031 SHALL hold in_ready=1 during reset (out_valid=0), but SHALL ignore any transfer while reset=1.
REQ-032 SHALL accept a new operand on the first rising edge after reset deassertion.

Structure
REQ-033 SHALL place default WIDTH and TAG_W constants, and the derived width helpers (root width, remainder width), in shared package isqrt_pkg.
REQ-034 SHALL instantiate N_STAGES copies of sub-module isqrt_stage via a generate loop.
REQ-035 isqrt_stage SHALL hold one register stage: valid, tag, remaining radicand bits, partial root, partial remainder, with enable input en.
REQ-036 SHALL keep the top level at 120-400 lines of RTL, including isqrt_stage.

Verification
REQ-037 Reset, then x=0..255 back-to-back with out_ready=1 -> first out_valid exactly 16 cycles after the first accept; y(0)=0, y(255)=15, rem(255)=30.
REQ-038 x=32'hFFFF_FFFF, x=32'hFFFE_0001, x=32'hFFFE_0000 -> (y,rem) = (65535,131070), (65535,0), (65534,131068).
REQ-039 Stream 256 $random operands with tags 0..255, toggling out_ready randomly at 50% -> every result satisfies REQ-025, tags arrive 0..255 in order, and outputs are stable while stalled.
REQ-040 in_valid alternating 1/0, out_ready=1 -> out_valid alternates 1/0, with 16-cycle latency preserved.
REQ-041 Fill the pipe with 10 operands, then assert reset for 1 cycle mid-stream -> out_valid=0 at once, and no stale result appears within 20 cycles after release.
REQ-042 WIDTH=8 instance, exhaustive x=0..255 -> 4-cycle latency, y and rem correct for all 256 values.

Source files
------------

// File: rtl/isqrt_pkg.sv
// Shared widths and helpers for the pipelined integer square root.
package isqrt_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_TAG_W = 8;

  // Root bits resolved by a WIDTH-bit radicand.
  function automatic int unsigned root_w(input int unsigned width);
    return width / 2;
  endfunction

  // Internal partial remainder width: wide enough for the trial subtraction at every stage.
  function automatic int unsigned rem_w(input int unsigned width);
    return width / 2 + 2;
  endfunction

  // Final remainder width: x - y*y never exceeds 2*y.
  function automatic int unsigned rem_out_w(input int unsigned width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/isqrt_stage.sv
// One restoring square-root stage: resolves a single root bit and registers the slot.
module isqrt_stage
  import isqrt_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned TAG_W = DEF_TAG_W,
  localparam int unsigned RT_W = root_w(WIDTH),
  localparam int unsigned RM_W = rem_w(WIDTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              d_valid,
  input  logic [TAG_W-1:0]  d_tag,
  input  logic [WIDTH-1:0]  d_xr,
  input  logic [RT_W-1:0]   d_root,
  input  logic [RM_W-1:0]   d_rem,
  output logic              q_valid,
  output logic [TAG_W-1:0]  q_tag,
  output logic [WIDTH-1:0]  q_xr,
  output logic [RT_W-1:0]   q_root,
  output logic [RM_W-1:0]   q_rem
);

  logic [RM_W-1:0] rem_t;
  logic [RM_W-1:0] trial;
  logic [RM_W-1:0] rem_n;
  logic [RT_W-1:0] root_n;
  logic            fits;

  // Bring down the next two radicand bits and try subtracting 4*root+1.
  // The incoming remainder is at most 2*root, so its top two bits are always zero.
  always_comb begin
    rem_t  = RM_W'({d_rem, d_xr[WIDTH-1 -: 2]});
    trial  = {d_root, 2'b01};
    fits   = (rem_t >= trial);
    rem_n  = fits ? (rem_t - trial) : rem_t;
    root_n = {d_root[RT_W-2:0], fits};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_tag   <= '0;
      q_xr    <= '0;
      q_root  <= '0;
      q_rem   <= '0;
    end else if (en) begin
      q_valid <= d_valid;
      q_tag   <= d_tag;
      q_xr    <= d_xr << 2;
      q_root  <= root_n;
      q_rem   <= rem_n;
    end
  end

endmodule

// File: rtl/isqrt_pipe.sv
// Fully pipelined floor(sqrt(x)) with remainder; one root bit per stage, global stall.
module isqrt_pipe
  import isqrt_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      x,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH/2-1:0]    y,
  output logic [WIDTH/2:0]      rem,
  output logic [TAG_W-1:0]      out_tag
);

  localparam int unsigned N_STAGES = WIDTH / 2;
  localparam int unsigned RT_W     = root_w(WIDTH);
  localparam int unsigned RM_W     = rem_w(WIDTH);
  localparam int unsigned RO_W     = rem_out_w(WIDTH);

  logic             en;
  logic             vld_p  [0:N_STAGES];
  logic [TAG_W-1:0] tag_p  [0:N_STAGES];
  logic [WIDTH-1:0] xr_p   [0:N_STAGES];
  logic [RT_W-1:0]  root_p [0:N_STAGES];
  logic [RM_W-1:0]  rem_p  [0:N_STAGES];
  logic [WIDTH-1:0] unused_xr;

  // The whole pipe advances unless a finished result is waiting on the consumer.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign vld_p[0]  = in_valid;
  assign tag_p[0]  = in_tag;
  assign xr_p[0]   = x;
  assign root_p[0] = '0;
  assign rem_p[0]  = '0;

  for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
    isqrt_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .en      (en),
      .d_valid (vld_p[i]),
      .d_tag   (tag_p[i]),
      .d_xr    (xr_p[i]),
      .d_root  (root_p[i]),
      .d_rem   (rem_p[i]),
      .q_valid (vld_p[i+1]),
      .q_tag   (tag_p[i+1]),
      .q_xr    (xr_p[i+1]),
      .q_root  (root_p[i+1]),
      .q_rem   (rem_p[i+1])
    );
  end

  // Results come straight from the last stage's flops.
  assign out_valid = vld_p[N_STAGES];
  assign y         = root_p[N_STAGES];
  assign rem       = RO_W'(rem_p[N_STAGES]);
  assign out_tag   = tag_p[N_STAGES];

  // Radicand is fully consumed by the last stage.
  assign unused_xr = xr_p[N_STAGES];

endmodule
